// File: rtl/cell_fetch.sv
// Fetches 16-cell board words once per 64-pixel span and emits the alive state per pixel.
// Latency 4 cycles from hcount_in/vcount_in to outputs; no backpressure (free-running pixel stream).
module cell_fetch #(
    parameter int SCREEN_WIDTH  = 1024,
    parameter int SCREEN_HEIGHT = 768,
    parameter int CELL_SHIFT    = 2,
    parameter int WORDS_PER_ROW = 16
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    output logic        mem_rd_out,
    output logic [11:0] mem_addr_out,
    input  logic [15:0] mem_data_in,
    output logic        is_alive_out,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        active_out
);

    logic              in_range;
    logic              fetch;
    logic              mem_rd_d, mem_rd_q;
    logic [11:0]       mem_addr_d, mem_addr_q;
    logic [1:0]        strb_d, strb_q;
    logic [15:0]       word_d, word_q;
    logic [3:0][10:0]  h_d, h_q;
    logic [3:0][9:0]   v_d, v_q;
    logic [3:0]        act_d, act_q;
    logic              alive_d, alive_q;

    always_comb begin
        in_range   = ({21'd0, hcount_in} < 32'(SCREEN_WIDTH)) &&
                     ({22'd0, vcount_in} < 32'(SCREEN_HEIGHT));
        fetch      = in_range && (hcount_in[5:0] == 6'd0);
        mem_rd_d   = fetch;
        mem_addr_d = mem_addr_q;
        if (fetch) begin
            mem_addr_d = 12'((32'(vcount_in) >> CELL_SHIFT) * 32'(WORDS_PER_ROW)
                             + 32'(hcount_in[10:6]));
        end
        // strb_q[1] marks the cycle whose mem_data_in answers our strobe
        strb_d = {strb_q[0], mem_rd_q};
        word_d = strb_q[1] ? mem_data_in : word_q;
        h_d    = {h_q[2:0], hcount_in};
        v_d    = {v_q[2:0], vcount_in};
        act_d  = {act_q[2:0], in_range};
        // word_d bypasses the capture so the first pixel of a span sees its own word
        alive_d = act_q[2] & word_d[h_q[2][5:CELL_SHIFT]];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            strb_q     <= '0;
            word_q     <= '0;
            h_q        <= '0;
            v_q        <= '0;
            act_q      <= '0;
            alive_q    <= 1'b0;
        end else begin
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            strb_q     <= strb_d;
            word_q     <= word_d;
            h_q        <= h_d;
            v_q        <= v_d;
            act_q      <= act_d;
            alive_q    <= alive_d;
        end
    end

    assign mem_rd_out   = mem_rd_q;
    assign mem_addr_out = mem_addr_q;
    assign is_alive_out = alive_q;
    assign hcount_out   = h_q[3];
    assign vcount_out   = v_q[3];
    assign active_out   = act_q[3];

endmodule

// File: tb/tb_cell_fetch.sv
// Directed bench for cell_fetch with a 2-cycle-latency board memory model.
module tb_cell_fetch;

    logic        clk_in    = 1'b0;
    logic        rst_n_in  = 1'b0;
    logic [10:0] hcount_in = 11'd1100;
    logic [9:0]  vcount_in = 10'd0;
    logic        mem_rd_out;
    logic [11:0] mem_addr_out;
    logic [15:0] mem_data_in;
    logic        is_alive_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        active_out;

    logic [15:0] mem [0:4095];
    logic        rd_d1 = 1'b0, rd_d2 = 1'b0;
    logic [11:0] a_d1 = '0, a_d2 = '0;
    logic        ovr_en  = 1'b0;
    logic [15:0] ovr_dat = 16'h0000;

    int n_cmp = 0;
    int n_bad = 0;

    cell_fetch dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .hcount_in    (hcount_in),
        .vcount_in    (vcount_in),
        .mem_rd_out   (mem_rd_out),
        .mem_addr_out (mem_addr_out),
        .mem_data_in  (mem_data_in),
        .is_alive_out (is_alive_out),
        .hcount_out   (hcount_out),
        .vcount_out   (vcount_out),
        .active_out   (active_out)
    );

    always #5 clk_in = ~clk_in;

    // Memory: data valid exactly 2 cycles after the strobe, junk otherwise.
    always @(posedge clk_in) begin
        rd_d1 <= mem_rd_out;
        rd_d2 <= rd_d1;
        a_d1  <= mem_addr_out;
        a_d2  <= a_d1;
    end
    assign mem_data_in = ovr_en ? ovr_dat : (rd_d2 ? mem[a_d2] : 16'hDEAD);

    task automatic drive(input int h, input int v);
        @(posedge clk_in);
        #1;
        hcount_in = 11'(h);
        vcount_in = 10'(v);
    endtask

    task automatic test_reset();
        drive(0, 0);
        drive(0, 0);
        n_cmp++; if (mem_rd_out !== 1'b0) begin n_bad++; $display("FAIL rst_rd got %b want 0", mem_rd_out); end
        n_cmp++; if (mem_addr_out !== 12'd0) begin n_bad++; $display("FAIL rst_addr got %0d want 0", mem_addr_out); end
        n_cmp++; if (is_alive_out !== 1'b0) begin n_bad++; $display("FAIL rst_alive got %b want 0", is_alive_out); end
        n_cmp++; if (hcount_out !== 11'd0) begin n_bad++; $display("FAIL rst_hout got %0d want 0", hcount_out); end
        n_cmp++; if (vcount_out !== 10'd0) begin n_bad++; $display("FAIL rst_vout got %0d want 0", vcount_out); end
        n_cmp++; if (active_out !== 1'b0) begin n_bad++; $display("FAIL rst_active got %b want 0", active_out); end
        drive(1100, 0);
        rst_n_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1100, 0);
            n_cmp++; if (is_alive_out !== 1'b0) begin n_bad++; $display("FAIL post_rst_alive cyc %0d got %b want 0", i, is_alive_out); end
        end
    endtask

    task automatic test_span0();
        int h, p;
        mem[0] = 16'h0001;
        for (int i = 0; i < 68; i++) begin
            h = (i < 64) ? i : 1024 + i;
            drive(h, 0);
            n_cmp++; if (mem_rd_out !== (i == 1)) begin n_bad++; $display("FAIL span0_rd cyc %0d got %b want %b", i, mem_rd_out, (i == 1)); end
            if (i == 1) begin
                n_cmp++; if (mem_addr_out !== 12'd0) begin n_bad++; $display("FAIL span0_addr got %0d want 0", mem_addr_out); end
            end
            if (i >= 4) begin
                p = i - 4;
                n_cmp++; if (hcount_out !== 11'(p)) begin n_bad++; $display("FAIL span0_hout got %0d want %0d", hcount_out, p); end
                n_cmp++; if (is_alive_out !== (p < 4)) begin n_bad++; $display("FAIL span0_alive pix %0d got %b want %b", p, is_alive_out, (p < 4)); end
            end
        end
    endtask

    task automatic test_pattern();
        int h, p;
        mem[34] = 16'hAAAA;
        for (int i = 0; i < 68; i++) begin
            h = (i < 64) ? 128 + i : 1100;
            drive(h, 9);
            if (i == 1) begin
                n_cmp++; if (mem_rd_out !== 1'b1) begin n_bad++; $display("FAIL pat_rd got %b want 1", mem_rd_out); end
                n_cmp++; if (mem_addr_out !== 12'd34) begin n_bad++; $display("FAIL pat_addr got %0d want 34", mem_addr_out); end
            end
            if (i >= 4) begin
                p = i - 4;
                n_cmp++; if (is_alive_out !== 1'((p >> 2) & 1)) begin n_bad++; $display("FAIL pat_alive pix %0d got %b want %0d", 128 + p, is_alive_out, (p >> 2) & 1); end
                n_cmp++; if (vcount_out !== 10'd9) begin n_bad++; $display("FAIL pat_vout got %0d want 9", vcount_out); end
            end
        end
    endtask

    task automatic test_blanking();
        int h, p;
        mem[95] = 16'hFFFF;
        for (int i = 0; i < 388; i++) begin
            h = (i < 64) ? 960 + i : (i < 384 ? 1024 + (i - 64) : 1100);
            drive(h, 20);
            if (i == 1) begin
                n_cmp++; if (mem_addr_out !== 12'd95) begin n_bad++; $display("FAIL blank_addr got %0d want 95", mem_addr_out); end
            end
            if (i >= 65) begin
                n_cmp++; if (mem_rd_out !== 1'b0) begin n_bad++; $display("FAIL blank_rd cyc %0d got %b want 0", i, mem_rd_out); end
            end
            if (i >= 4) begin
                p = i - 4;
                n_cmp++; if (active_out !== (p < 64)) begin n_bad++; $display("FAIL blank_active pix %0d got %b want %b", p, active_out, (p < 64)); end
                n_cmp++; if (is_alive_out !== (p < 64)) begin n_bad++; $display("FAIL blank_alive pix %0d got %b want %b", p, is_alive_out, (p < 64)); end
            end
        end
    endtask

    task automatic test_jump();
        int seq[$];
        int p;
        logic [15:0] w16, w18, w;
        logic exp;
        w16 = 16'h00F0;
        w18 = 16'h0003;
        mem[16] = w16;
        mem[17] = 16'hFFFF;
        mem[18] = w18;
        for (int h = 0; h <= 10; h++) seq.push_back(h);
        for (int h = 70; h <= 135; h++) seq.push_back(h);
        for (int k = 0; k < 4; k++) seq.push_back(1100);
        for (int i = 0; i < seq.size(); i++) begin
            drive(seq[i], 4);
            n_cmp++; if (mem_rd_out !== (i == 1 || i == 70)) begin n_bad++; $display("FAIL jump_rd cyc %0d got %b want %b", i, mem_rd_out, (i == 1 || i == 70)); end
            if (i == 1 || i == 70) begin
                n_cmp++; if (mem_addr_out !== ((i == 1) ? 12'd16 : 12'd18)) begin n_bad++; $display("FAIL jump_addr cyc %0d got %0d", i, mem_addr_out); end
            end
            if (i >= 4) begin
                p = seq[i - 4];
                w = (p < 128) ? w16 : w18;
                exp = (p < 1024) ? w[(p >> 2) & 15] : 1'b0;
                n_cmp++; if (is_alive_out !== exp) begin n_bad++; $display("FAIL jump_alive pix %0d got %b want %b", p, is_alive_out, exp); end
            end
        end
    endtask

    task automatic test_reset_mid();
        mem[1] = 16'hFFFF;
        mem[2] = 16'h000F;
        for (int h = 60; h <= 64; h++) drive(h, 0);
        drive(65, 0);
        n_cmp++; if (mem_rd_out !== 1'b1) begin n_bad++; $display("FAIL mid_rd_pre got %b want 1", mem_rd_out); end
        rst_n_in = 1'b0;
        #1;
        n_cmp++; if (mem_rd_out !== 1'b0) begin n_bad++; $display("FAIL mid_rd got %b want 0", mem_rd_out); end
        n_cmp++; if (mem_addr_out !== 12'd0) begin n_bad++; $display("FAIL mid_addr got %0d want 0", mem_addr_out); end
        n_cmp++; if (is_alive_out !== 1'b0) begin n_bad++; $display("FAIL mid_alive got %b want 0", is_alive_out); end
        n_cmp++; if (hcount_out !== 11'd0) begin n_bad++; $display("FAIL mid_hout got %0d want 0", hcount_out); end
        n_cmp++; if (vcount_out !== 10'd0) begin n_bad++; $display("FAIL mid_vout got %0d want 0", vcount_out); end
        n_cmp++; if (active_out !== 1'b0) begin n_bad++; $display("FAIL mid_active got %b want 0", active_out); end
        ovr_dat = 16'hFFFF;
        ovr_en  = 1'b1;
        for (int h = 66; h <= 140; h++) begin
            drive(h, 0);
            if (h == 66) rst_n_in = 1'b1;
            if (h == 71) ovr_en = 1'b0;
            n_cmp++; if (mem_rd_out !== (h == 129)) begin n_bad++; $display("FAIL mid_strobe h %0d got %b want %b", h, mem_rd_out, (h == 129)); end
            if (h == 129) begin
                n_cmp++; if (mem_addr_out !== 12'd2) begin n_bad++; $display("FAIL mid_addr2 got %0d want 2", mem_addr_out); end
            end
            n_cmp++; if (is_alive_out !== (h >= 132)) begin n_bad++; $display("FAIL mid_alive_after h %0d got %b want %b", h, is_alive_out, (h >= 132)); end
        end
    endtask

    task automatic test_frame();
        localparam int LINE  = 1344;
        localparam int LINES = 8;
        int n, q, ph, pv;
        int strobes [LINES];
        logic [15:0] w;
        logic exp;
        for (int a = 0; a < 32; a++) mem[a] = 16'((a * 40503 + 7919) ^ 16'h5A5A);
        for (int l = 0; l < LINES; l++) strobes[l] = 0;
        n = LINE * LINES + 4;
        for (int c = 0; c < n; c++) begin
            if (c < LINE * LINES) drive(c % LINE, c / LINE);
            else drive(1100, LINES);
            if (c >= 1 && (c - 1) < LINE * LINES && mem_rd_out === 1'b1) strobes[(c - 1) / LINE]++;
            if (c >= 4) begin
                q  = c - 4;
                ph = q % LINE;
                pv = q / LINE;
                w  = mem[(pv >> 2) * 16 + (ph >> 6)];
                exp = (ph < 1024) ? w[(ph >> 2) & 15] : 1'b0;
                n_cmp++; if (is_alive_out !== exp) begin n_bad++; $display("FAIL frame_alive v %0d h %0d got %b want %b", pv, ph, is_alive_out, exp); end
                n_cmp++; if (active_out !== (ph < 1024)) begin n_bad++; $display("FAIL frame_active v %0d h %0d got %b", pv, ph, active_out); end
            end
        end
        for (int l = 0; l < LINES; l++) begin
            n_cmp++; if (strobes[l] !== 16) begin n_bad++; $display("FAIL frame_strobes line %0d got %0d want 16", l, strobes[l]); end
        end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 16'h0000;
        test_reset();
        test_span0();
        test_pattern();
        test_blanking();
        test_jump();
        test_reset_mid();
        test_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cell_fetch.md
CELL_FETCH -- requirements
Module: cell_fetch

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 1024: active pixels per line.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 768: active lines per frame.
REQ-003 SHALL have parameter CELL_SHIFT, default 2: cell edge of 2^CELL_SHIFT pixels, so 4x4 pixels per cell.
REQ-004 SHALL have parameter WORDS_PER_ROW, default 16: 16-cell memory words per cell row.
REQ-005 SHALL have port clk_in, input, 1: single clock (pixel clock); all logic on its rising edge.
REQ-006 SHALL have port rst_n_in, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port hcount_in, input, 11: current pixel column, advancing by 1 per cycle.
REQ-008 SHALL have port vcount_in, input, 10: current pixel line.
REQ-009 SHALL have port mem_rd_out, output, 1: one-cycle board-memory read strobe.
REQ-010 SHALL have port mem_addr_out, output, 12: word address, = cell_row*WORDS_PER_ROW + word_idx.
REQ-011 SHALL have port mem_data_in, input, 16: read data, valid exactly 2 cycles after mem_rd_out; bit j = j-th cell from the left.
REQ-012 SHALL have port is_alive_out, output, 1: state of the cell under the delayed pixel; feeds cell_render is_alive_in.
REQ-013 SHALL have port hcount_out, output, 11: hcount_in delayed 4 cycles.
REQ-014 SHALL have port vcount_out, output, 10: vcount_in delayed 4 cycles.
REQ-015 SHALL have port active_out, output, 1: delayed pixel lies inside SCREEN_WIDTH x SCREEN_HEIGHT.

Function
REQ-016 SHALL define cycle t as a cycle in which hcount_in < SCREEN_WIDTH, vcount_in < SCREEN_HEIGHT and hcount_in[5:0] == 0; t is a fetch cycle.
REQ-017 SHALL register mem_rd_out = 1 in cycle t+1 and 0 in every other cycle, giving one strobe per 64-pixel span.
REQ-018 SHALL drive mem_addr_out in cycle t+1 as (vcount_in>>CELL_SHIFT)*WORDS_PER_ROW + hcount_in[10:6], using the values sampled at t; truncated to 12 bits; held otherwise.
REQ-019 SHALL capture mem_data_in into a word register at the end of cycle t+3, and hold it until the next capture.
REQ-020 SHALL make the pixel pipeline (hcount, vcount, active) exactly 4 registers deep; outputs in cycle t+4 correspond to inputs in cycle t.
REQ-021 SHALL drive is_alive_out = word_reg[hcount_out[5:CELL_SHIFT]] when active_out = 1, else 0; registered, aligned with hcount_out.
REQ-022 SHALL issue no reads and force active_out = 0 and is_alive_out = 0 in blanking (hcount or vcount out of range).
REQ-023 SHALL capture mem_data_in only when a strobe was issued 2 cycles earlier, via a 2-deep strobe shift register; it SHALL ignore mem_data_in at all other times.
REQ-024 SHALL perform no fetch for a span entered mid-word (hcount_in jumps past [5:0] == 0); is_alive_out then reflects the previously held word.
REQ-025 SHALL fetch every line independently; the same word is read again for all 2^CELL_SHIFT lines of a cell row.
REQ-026 SHALL NOT change is_alive_out within a 2^CELL_SHIFT-pixel run belonging to one cell.

Reset
REQ-027 SHALL, while rst_n_in = 0, immediately clear mem_rd_out, mem_addr_out, is_alive_out, hcount_out, vcount_out, active_out, the word register and the strobe pipeline to 0.
REQ-028 SHALL, when reset asserts mid-fetch, drop the outstanding read; the data that follows is not captured.
REQ-029 SHALL, after release, drive is_alive_out = 0 until the first completed fetch, and resume normal operation at the next fetch cycle.

Verification
REQ-030 SHALL pass: memory holds word 0 = 16'h0001, hcount 0..63 on line 0 -> mem_rd_out at cycle 1 with addr 0; hcount_out = 0..3 with is_alive_out = 1; hcount_out = 4..63 with is_alive_out = 0.
REQ-031 SHALL pass: vcount = 9, hcount sweeps 128..191 -> addr = 2*16 + 2 = 34; pattern 16'hAAAA -> is_alive_out alternates 0/1 every 4 pixels, starting with 0.
REQ-032 SHALL pass: hcount 1024..1343 (blanking) -> mem_rd_out stays 0 and active_out = 0; is_alive_out = 0 even when the word register is all ones.
REQ-033 SHALL pass: full 1024x768 frame sweep against a reference board -> exactly 16 strobes per active line; every pixel's is_alive_out equals board[v>>2][h>>2] at 4-cycle latency.
REQ-034 SHALL pass: rst_n_in pulsed low at hcount = 65 while mem_data_in = 16'hFFFF is pending -> all outputs 0 at once; is_alive_out = 0 until the fetch at hcount = 128 completes.
REQ-035 SHALL pass: hcount_in jumps from 10 to 70 -> no strobe for span 64; pixels 70..127 use the word from span 0; a strobe is issued at hcount_in = 128.
